// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core: walks the tuning word from start to stop
// with a programmable step and dwell, in single, sawtooth, triangle or static-tone mode.
module dds_sweep_ctrl #(
  parameter int unsigned TUNE    = 16,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TUNE-1:0]    cfg_start,
  input  logic [TUNE-1:0]    cfg_stop,
  input  logic [TUNE-1:0]    cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [2:0]         cfg_sel,
  input  logic               abort,
  output logic [TUNE-1:0]    tuningW,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam logic [1:0] ModeSingle = 2'd0;
  localparam logic [1:0] ModeSaw    = 2'd1;
  localparam logic [1:0] ModeStatic = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e              state_q;
  logic [TUNE-1:0]     start_q, stop_q, step_q, tune_q;
  logic [DWELL_W-1:0]  dwell_q, cnt_q;
  logic [1:0]          mode_q;
  logic                up_q;
  logic [2:0]          sel_q;
  logic                done_q, wrap_q;
  logic [TUNE-1:0]     fwd_word, rev_word;

  // One step toward tgt, clamped to tgt; the extra bit catches overflow/underflow.
  function automatic logic [TUNE-1:0] step_toward(input logic [TUNE-1:0] cur,
                                                  input logic [TUNE-1:0] tgt,
                                                  input logic [TUNE-1:0] stp,
                                                  input logic            up);
    logic [TUNE:0]   nxt;
    logic [TUNE-1:0] res;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      res = (nxt >= {1'b0, tgt}) ? tgt : nxt[TUNE-1:0];
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      res = (nxt[TUNE] || (nxt[TUNE-1:0] <= tgt)) ? tgt : nxt[TUNE-1:0];
    end
    return res;
  endfunction

  // rev_word is the triangle turnaround: step off the old stop back toward the old start.
  always_comb begin
    fwd_word = step_toward(tune_q, stop_q, step_q, up_q);
    rev_word = step_toward(tune_q, start_q, step_q, ~up_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      tune_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      mode_q  <= ModeSingle;
      up_q    <= 1'b0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            start_q <= cfg_start;
            stop_q  <= cfg_stop;
            step_q  <= cfg_step;
            dwell_q <= cfg_dwell;
            mode_q  <= cfg_mode;
            tune_q  <= cfg_start;
            sel_q   <= cfg_sel;
            cnt_q   <= cfg_dwell;
            up_q    <= (cfg_stop >= cfg_start);
            if (cfg_mode == ModeStatic || cfg_step == '0 || cfg_start == cfg_stop) begin
              state_q <= StHold;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (tune_q != stop_q) begin
            tune_q <= fwd_word;
            cnt_q  <= dwell_q;
          end else begin
            case (mode_q)
              ModeSingle: begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
              ModeSaw: begin
                tune_q <= start_q;
                cnt_q  <= dwell_q;
                wrap_q <= 1'b1;
              end
              default: begin
                start_q <= stop_q;
                stop_q  <= start_q;
                up_q    <= ~up_q;
                tune_q  <= rev_word;
                cnt_q   <= dwell_q;
                wrap_q  <= 1'b1;
              end
            endcase
          end
        end
        StHold: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (mode_q == ModeSingle && start_q == stop_q) begin
            // Degenerate single sweep: hold the one word for its dwell, then finish.
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tuningW   = tune_q;
  assign sel       = sel_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a trace-generating sweep model checked every cycle, plus
// literal expectations on the directed vectors.
module tb_dds_sweep_ctrl;

  localparam int Cap = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_stop = '0;
  logic [15:0] cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [2:0]  cfg_sel = '0;
  logic        abort = 1'b0;
  logic [15:0] tuningW;
  logic [2:0]  sel;
  logic        busy;
  logic        done;
  logic        wrap;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.TUNE(16), .DWELL_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .cfg_sel   (cfg_sel),
    .abort     (abort),
    .tuningW   (tuningW),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  typedef struct {
    int tw;
    bit busy;
    bit done;
    bit wrap;
  } ent_t;

  ent_t q[$];
  int   exp_tw = 0;
  int   exp_sel = 0;
  bit   exp_busy = 0;
  bit   exp_done = 0;
  bit   exp_wrap = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int toward(input int w, input int t, input int st);
    if (t > w) return (w + st >= t) ? t : w + st;
    return (w - st <= t) ? t : w - st;
  endfunction

  task automatic push_ent(input int w, input bit b, input bit d, input bit r);
    ent_t e;
    e.tw = w; e.busy = b; e.done = d; e.wrap = r;
    q.push_back(e);
  endtask

  task automatic push_word(input int w, input int dw, input bit r);
    for (int i = 0; i <= dw; i++) push_ent(w, 1'b1, 1'b0, r && (i == 0));
  endtask

  // Expected per-cycle outputs of a whole sweep, starting with the accept cycle.
  task automatic build(input int s, input int e, input int st, input int dw, input int md);
    int w, target;
    bit r;
    q.delete();
    if (md == 3 || st == 0 || s == e) begin
      if (md == 0 && s == e) begin
        push_word(s, dw, 1'b0);
        push_ent(s, 1'b0, 1'b1, 1'b0);
      end else begin
        for (int i = 0; i < Cap; i++) push_ent(s, 1'b1, 1'b0, 1'b0);
      end
      return;
    end
    w = s; target = e; r = 1'b0;
    while (q.size() < Cap) begin
      push_word(w, dw, r);
      r = 1'b0;
      if (w == target) begin
        if (md == 0) begin
          push_ent(w, 1'b0, 1'b1, 1'b0);
          return;
        end else if (md == 1) begin
          w = s;
        end else begin
          target = (target == e) ? s : e;
          w = toward(w, target, st);
        end
        r = 1'b1;
      end else begin
        w = toward(w, target, st);
      end
    end
  endtask

  task automatic take();
    ent_t e;
    e = q.pop_front();
    exp_tw = e.tw; exp_busy = e.busy; exp_done = e.done; exp_wrap = e.wrap;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_tw = 0; exp_sel = 0; exp_busy = 0; exp_done = 0; exp_wrap = 0;
    end else if (!exp_busy && cfg_valid) begin
      build(32'(cfg_start), 32'(cfg_stop), 32'(cfg_step), 32'(cfg_dwell), 32'(cfg_mode));
      exp_sel = 32'(cfg_sel);
      take();
    end else if (exp_busy && abort) begin
      q.delete();
      exp_busy = 0; exp_done = 0; exp_wrap = 0;
    end else if (q.size() > 0) begin
      take();
    end else begin
      exp_busy = 0; exp_done = 0; exp_wrap = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cyc_tuningW", 32'(tuningW), exp_tw);
      chk("cyc_sel", 32'(sel), exp_sel);
      chk("cyc_busy", 32'(busy), 32'(exp_busy));
      chk("cyc_done", 32'(done), 32'(exp_done));
      chk("cyc_wrap", 32'(wrap), 32'(exp_wrap));
      chk("cyc_ready", 32'(cfg_ready), 32'(!exp_busy));
    end
  end

  // Caller sits at a negedge; the descriptor is taken at the following posedge.
  task automatic accept(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                        input logic [15:0] dw, input logic [1:0] md, input logic [2:0] sl);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md; cfg_sel = sl;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int tri_w[7];
    int tri_r[7];
    tri_w = '{0, 3, 6, 3, 0, 3, 6};
    tri_r = '{0, 0, 0, 1, 0, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_tuningW", 32'(tuningW), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // single up with clamp on the last step
    accept(16'd0, 16'd10, 16'd4, 16'd0, 2'd0, 3'd1);
    chk("t1_w0", 32'(tuningW), 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(cfg_ready), 0);
    @(negedge clk); chk("t1_w1", 32'(tuningW), 4);
    @(negedge clk); chk("t1_w2", 32'(tuningW), 8);
    @(negedge clk); chk("t1_w3", 32'(tuningW), 10);
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_hold", 32'(tuningW), 10);

    // accepted in the same cycle done is high: down sweep with dwell
    accept(16'd100, 16'd90, 16'd5, 16'd2, 2'd0, 3'd4);
    chk("t2_w0", 32'(tuningW), 100);
    chk("t2_done_clr", 32'(done), 0);
    wait_done(n);
    chk("t2_done_lat", n, 9);
    chk("t2_hold", 32'(tuningW), 90);

    // sawtooth with overflow clamp
    accept(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 2'd1, 3'd2);
    chk("t3_w0", 32'(tuningW), 32'hFFF0);
    @(negedge clk); chk("t3_w1", 32'(tuningW), 32'hFFFF);
    @(negedge clk); chk("t3_w2", 32'(tuningW), 32'hFFF0);
    chk("t3_wrap", 32'(wrap), 1);
    repeat (6) @(negedge clk);
    do_abort();
    chk("t3_abort_busy", 32'(busy), 0);
    chk("t3_abort_done", 32'(done), 0);

    // triangle, with a descriptor held valid while busy
    accept(16'd0, 16'd6, 16'd3, 16'd0, 2'd2, 3'd5);
    cfg_start = 16'd500; cfg_stop = 16'd9; cfg_step = 16'd1; cfg_mode = 2'd0; cfg_sel = 3'd7;
    cfg_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_w", 32'(tuningW), tri_w[i]);
      chk("t4_wrap", 32'(wrap), tri_r[i]);
    end
    chk("t4_sel", 32'(sel), 5);
    chk("t4_busy", 32'(busy), 1);
    cfg_valid = 1'b0;
    do_abort();
    chk("t4_abort_busy", 32'(busy), 0);

    // static tone held, then abort
    accept(16'h3FFF, 16'd0, 16'd7, 16'd0, 2'd3, 3'b010);
    repeat (50) @(negedge clk);
    chk("t5_w", 32'(tuningW), 32'h3FFF);
    chk("t5_sel", 32'(sel), 2);
    chk("t5_busy", 32'(busy), 1);
    do_abort();
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_w", 32'(tuningW), 32'h3FFF);
    chk("t5_abort_done", 32'(done), 0);

    // abort mid-RUN holds the current word
    accept(16'd0, 16'd1000, 16'd1, 16'd0, 2'd0, 3'd1);
    repeat (5) @(negedge clk);
    chk("t6_w", 32'(tuningW), 5);
    do_abort();
    chk("t6_abort_w", 32'(tuningW), 5);
    chk("t6_abort_busy", 32'(busy), 0);
    chk("t6_abort_done", 32'(done), 0);

    // abort with cfg_valid in IDLE still accepts; single start==stop holds dwell+1
    abort = 1'b1;
    accept(16'd7, 16'd7, 16'd3, 16'd1, 2'd0, 3'd6);
    abort = 1'b0;
    chk("t7_w", 32'(tuningW), 7);
    chk("t7_busy", 32'(busy), 1);
    wait_done(n);
    chk("t7_done_lat", n, 2);

    // single down with underflow clamp
    accept(16'd5, 16'd0, 16'd7, 16'd0, 2'd0, 3'd0);
    chk("t8_w0", 32'(tuningW), 5);
    @(negedge clk); chk("t8_w1", 32'(tuningW), 0);
    @(negedge clk); chk("t8_done", 32'(done), 1);

    // zero step in sawtooth mode parks on start
    accept(16'd10, 16'd20, 16'd0, 16'd0, 2'd1, 3'd3);
    repeat (10) @(negedge clk);
    chk("t9_w", 32'(tuningW), 10);
    chk("t9_busy", 32'(busy), 1);
    do_abort();

    // asynchronous reset mid-sweep, then a clean sweep
    accept(16'd0, 16'd100, 16'd3, 16'd1, 2'd0, 3'd6);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t10_rst_w", 32'(tuningW), 0);
    chk("t10_rst_sel", 32'(sel), 0);
    chk("t10_rst_busy", 32'(busy), 0);
    chk("t10_rst_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    accept(16'd5, 16'd20, 16'd10, 16'd0, 2'd0, 3'd3);
    chk("t10_w0", 32'(tuningW), 5);
    chk("t10_sel", 32'(sel), 3);
    @(negedge clk); chk("t10_w1", 32'(tuningW), 15);
    @(negedge clk); chk("t10_w2", 32'(tuningW), 20);
    @(negedge clk); chk("t10_done", 32'(done), 1);
    @(negedge clk); chk("t10_done_clr", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that drives the tuning word and waveform select of the DDS core. It accepts a sweep descriptor through a valid/ready handshake, then steps the tuning word from a start value toward a stop value with a programmable step and dwell. It supports single-shot, sawtooth-repeat, triangle and static-tone modes, so one configuration can produce chirps and frequency hops without per-step host writes.

## Interface
- TUNE, 16, tuning-word width; matches the DDS core `tuningW`.
- DWELL_W, 16, dwell counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  descriptor accepted when `cfg_valid & cfg_ready` at a rising edge.
- cfg_start  in  TUNE  first tuning word.
- cfg_stop  in  TUNE  final tuning word.
- cfg_step  in  TUNE  unsigned step magnitude.
- cfg_dwell  in  DWELL_W  extra cycles each word is held; hold time = dwell+1.
- cfg_mode  in  2  0 single, 1 sawtooth, 2 triangle, 3 static.
- cfg_sel  in  3  waveform select forwarded to DDS `sel`.
- abort  in  1  stop the sweep, return to IDLE.
- tuningW  out  TUNE  registered tuning word to DDS.
- sel  out  3  registered waveform select to DDS.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at normal completion of a single sweep.
- wrap  out  1  one-cycle pulse when sawtooth reloads or triangle reverses.

## Operation
- Reset: the controller enters IDLE. All outputs reset to 0: `tuningW`=0, `sel`=0, `busy`=0, `done`=0, `wrap`=0. `cfg_ready`=1 because it is decoded from IDLE.
- States: IDLE, RUN, HOLD. `cfg_ready` = (state==IDLE). `cfg_valid` is ignored outside IDLE.
- Accept (IDLE):
  - Latch stop, step, mode, dwell and start.
  - Load `tuningW`<=cfg_start, `sel`<=cfg_sel and dwell_cnt<=cfg_dwell.
  - Set dir=up if cfg_stop>=cfg_start, else down.
  - Go to HOLD if mode==3, step==0 or start==stop; otherwise go to RUN.
- RUN: dwell_cnt decrements each cycle. When it is 0, the dwell has expired and the controller does the following:
  - If `tuningW`!=stop, compute next = tuningW ± step in TUNE+1 bits.
  - If next passes or equals stop (overflow or underflow included), load stop; otherwise load next. Reload dwell_cnt.
  - If `tuningW`==stop, the end action depends on mode:
    - Single: go to IDLE, pulse `done`, hold `tuningW`=stop.
    - Sawtooth: `tuningW`<=start, reload dwell, pulse `wrap`.
    - Triangle: swap the latched start and stop, invert dir, and step once from the old stop toward the new stop with the same clamp rule; pulse `wrap`.
- HOLD: `tuningW` stays constant and `busy`=1 until abort. A single-mode descriptor with start==stop is the exception: it holds for dwell+1 cycles, then completes as single, with `done`.
- abort in RUN or HOLD: at the next edge go to IDLE. `tuningW` and `sel` hold their current values, with no `done` and no `wrap`. abort in IDLE has no effect. If abort and `cfg_valid` are both high in IDLE, the descriptor is accepted.
- All arithmetic is unsigned. `tuningW` never leaves the closed interval [min(start,stop), max(start,stop)].
- Reset mid-sweep clears everything asynchronously. The next accept starts cleanly.

## Timing
- Accept at edge k: `tuningW`=cfg_start, `busy`=1 and `cfg_ready`=0 are all visible after edge k.
- Each word is held exactly dwell+1 cycles, including the start and clamped-stop words.
- Single completion: at the edge ending stop's dwell, `busy`=0, `done`=1 and `cfg_ready`=1 appear together. `done` clears the following cycle. A new descriptor can be accepted in the same cycle `done` is high.
- `wrap` is high for exactly the cycle in which the reloaded or reversed word is first presented.
- `sel` changes only on accept. `tuningW` is registered, with no combinational path from cfg_* to outputs.

## Test plan
- Single up: start=0, stop=10, step=4, dwell=0, mode 0 -> `tuningW` is 0,4,8,10 on consecutive cycles; on the next cycle `busy`=0 and `done`=1 for one cycle; `tuningW` holds 10.
- Dwell and down: start=100, stop=90, step=5, dwell=2 -> 100,95,90, each held 3 cycles; `done` is asserted 9 cycles after accept.
- Overflow clamp: start=16'hFFF0, stop=16'hFFFF, step=16'h0020, mode 1, dwell 0 -> FFF0, FFFF, then `wrap`=1 with FFF0, repeating; no wrap-around to low values.
- Triangle: start=0, stop=6, step=3, dwell=0, mode 2 -> 0,3,6,3(`wrap`),0,3(`wrap`),6,... continuously with `busy`=1.
- Abort and static: mode 3, start=16'h3FFF, cfg_sel=3'b010 -> `tuningW`=3FFF and `sel`=2 held for 50 cycles; abort -> IDLE next edge, outputs held, no `done`. Abort mid-RUN behaves the same.
- Handshake/reset: hold `cfg_valid` high while busy -> ignored; drop rst_n mid-sweep -> all outputs 0 immediately and `cfg_ready`=1.
